ow_slot_driver: RTL and testbench

1-Wire master bus slot generator, downstream of the master's parallel-to-serial stage. Consumes one serial bit plus a bit strobe per bit period and turns each bit into a timed write slot on the open-drain DQ line. Also generates the bus reset pulse and samples the slave presence pulse on request. All timing is in clk cycles; defaults assume 1 clk = 1 µs.

---
 rtl/ow_slot_driver.sv | 203 ++++++++++++++++++++
 tb/tb_ow_slot_driver.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ow_slot_driver.sv
// ============================================================================
// Module  : ow_slot_driver
// Purpose : 1-Wire master slot generator: write slots, bus reset, presence.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ow_slot_driver #(
  parameter int T_LOW1   = 6,
  parameter int T_LOW0   = 60,
  parameter int T_SLOT   = 70,
  parameter int T_RSTL   = 480,
  parameter int T_RSTH   = 480,
  parameter int T_PDWAIT = 70,
  parameter int CNT_W    = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_bit,
  input  logic i_bit_strobe,
  input  logic i_done,
  input  logic i_bus_reset_req,
  input  logic i_dq,
  output logic o_dq_oe,
  output logic o_busy,
  output logic o_slot_done,
  output logic o_frame_done,
  output logic o_overrun,
  output logic o_presence,
  output logic o_presence_valid
);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_wr_low   = 3'd1;
  localparam logic [2:0] c_wr_rel   = 3'd2;
  localparam logic [2:0] c_rst_low  = 3'd3;
  localparam logic [2:0] c_rst_high = 3'd4;

  // Counter reload values: each state lasts (load + 1) cycles.
  localparam logic [CNT_W-1:0] c_low1_ld = CNT_W'(T_LOW1 - 1);
  localparam logic [CNT_W-1:0] c_low0_ld = CNT_W'(T_LOW0 - 1);
  localparam logic [CNT_W-1:0] c_rel1_ld = CNT_W'(T_SLOT - T_LOW1 - 1);
  localparam logic [CNT_W-1:0] c_rel0_ld = CNT_W'(T_SLOT - T_LOW0 - 1);
  localparam logic [CNT_W-1:0] c_rstl_ld = CNT_W'(T_RSTL - 1);
  localparam logic [CNT_W-1:0] c_rsth_ld = CNT_W'(T_RSTH - 1);
  localparam logic [CNT_W-1:0] c_pd_cnt  = CNT_W'(T_RSTH - T_PDWAIT);

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_load;
  logic             w_load;
  logic             w_cnt_zero;
  logic             w_wr_active;
  logic             w_rst_start;
  logic             w_slot_done;
  logic             r_bit;
  logic             r_dq_meta;
  logic             r_dq_s;
  logic             r_rst_pend;
  logic             r_done_pend;
  logic             r_dq_oe;
  logic             r_frame_done;
  logic             r_overrun;
  logic             r_presence;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_wr_active = (r_state == c_wr_low) || (r_state == c_wr_rel);
  assign w_rst_start = (w_state_next == c_rst_low) && (r_state != c_rst_low);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load)
        r_cnt <= w_cnt_load;
      else if (!w_cnt_zero)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_cnt_load   = '0;
    case (r_state)
      c_idle: begin
        if (i_bus_reset_req) begin
          w_state_next = c_rst_low;
          w_load       = 1'b1;
          w_cnt_load   = c_rstl_ld;
        end else if (i_bit_strobe) begin
          w_state_next = c_wr_low;
          w_load       = 1'b1;
          w_cnt_load   = i_bit ? c_low1_ld : c_low0_ld;
        end
      end
      c_wr_low: begin
        if (w_cnt_zero) begin
          w_state_next = c_wr_rel;
          w_load       = 1'b1;
          w_cnt_load   = r_bit ? c_rel1_ld : c_rel0_ld;
        end
      end
      c_wr_rel: begin
        if (w_cnt_zero) begin
          w_load = 1'b1;
          // A reset requested mid-slot starts right after the slot ends.
          if (r_rst_pend || i_bus_reset_req) begin
            w_state_next = c_rst_low;
            w_cnt_load   = c_rstl_ld;
          end else begin
            w_state_next = c_idle;
          end
        end
      end
      c_rst_low: begin
        if (w_cnt_zero) begin
          w_state_next = c_rst_high;
          w_load       = 1'b1;
          w_cnt_load   = c_rsth_ld;
        end
      end
      c_rst_high: begin
        if (w_cnt_zero) begin
          w_state_next = c_idle;
          w_load       = 1'b1;
        end
      end
      default: begin
        w_state_next = c_idle;
        w_load       = 1'b1;
      end
    endcase
  end

  always_comb begin
    o_busy           = (r_state != c_idle);
    w_slot_done      = (r_state == c_wr_rel) && w_cnt_zero;
    o_slot_done      = w_slot_done;
    o_presence_valid = (r_state == c_rst_high) && w_cnt_zero;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dq_meta <= 1'b1;
      r_dq_s    <= 1'b1;
    end else begin
      r_dq_meta <= i_dq;
      r_dq_s    <= r_dq_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit        <= 1'b0;
      r_rst_pend   <= 1'b0;
      r_done_pend  <= 1'b0;
      r_dq_oe      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_presence   <= 1'b0;
    end else begin
      if (r_state == c_idle && i_bit_strobe && !i_bus_reset_req)
        r_bit <= i_bit;

      if (w_rst_start)
        r_rst_pend <= 1'b0;
      else if (i_bus_reset_req && w_wr_active)
        r_rst_pend <= 1'b1;

      if (w_slot_done)
        r_done_pend <= 1'b0;
      else if (i_done && w_wr_active)
        r_done_pend <= 1'b1;

      r_frame_done <= (i_done && !w_wr_active) ||
                      (w_slot_done && (r_done_pend || i_done));

      r_dq_oe <= (w_state_next == c_wr_low) || (w_state_next == c_rst_low);

      if (w_rst_start)
        r_overrun <= 1'b0;
      else if (i_bit_strobe && r_state != c_idle)
        r_overrun <= 1'b1;

      if (w_rst_start)
        r_presence <= 1'b0;
      else if (r_state == c_rst_high && r_cnt == c_pd_cnt)
        r_presence <= ~r_dq_s;
    end
  end

  assign o_dq_oe      = r_dq_oe;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;
  assign o_presence   = r_presence;

endmodule

`default_nettype wire

// File: tb/tb_ow_slot_driver.sv
// ============================================================================
// Module  : tb_ow_slot_driver
// Purpose : Self-checking bench for ow_slot_driver against a timestamp model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ow_slot_driver;

  localparam int T_LOW1   = 6;
  localparam int T_LOW0   = 60;
  localparam int T_SLOT   = 70;
  localparam int T_RSTL   = 480;
  localparam int T_RSTH   = 480;
  localparam int T_PDWAIT = 70;
  localparam int CNT_W    = 10;

  logic clk = 1'b0;
  logic reset;
  logic i_bit, i_bit_strobe, i_done, i_bus_reset_req, i_dq;
  logic o_dq_oe, o_busy, o_slot_done, o_frame_done, o_overrun, o_presence, o_presence_valid;

  always #5 clk = ~clk;

  ow_slot_driver #(
    .T_LOW1(T_LOW1), .T_LOW0(T_LOW0), .T_SLOT(T_SLOT), .T_RSTL(T_RSTL),
    .T_RSTH(T_RSTH), .T_PDWAIT(T_PDWAIT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .i_bit(i_bit), .i_bit_strobe(i_bit_strobe),
    .i_done(i_done), .i_bus_reset_req(i_bus_reset_req), .i_dq(i_dq),
    .o_dq_oe(o_dq_oe), .o_busy(o_busy), .o_slot_done(o_slot_done),
    .o_frame_done(o_frame_done), .o_overrun(o_overrun), .o_presence(o_presence),
    .o_presence_valid(o_presence_valid)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pull_lo = -1;
  int pull_hi = -1;
  int sd_cnt = 0;
  int fd_cnt = 0;
  logic dq_hist [0:65535];

  // Reference model: activity described by start timestamps, not states.
  bit have_w, have_r, pend, done_pend;
  int w_s, w_l, r_s, fd_due;
  logic ov_m, pres_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    have_w = 0; have_r = 0; pend = 0; done_pend = 0;
    w_s = 0; w_l = 0; r_s = 0; fd_due = -1;
    ov_m = 1'b0; pres_m = 1'b0;
  endtask

  function automatic bit in_write(input int c);
    return have_w && c > w_s && c <= w_s + T_SLOT;
  endfunction

  function automatic bit in_rst(input int c);
    return have_r && c > r_s && c <= r_s + T_RSTL + T_RSTH;
  endfunction

  task automatic check_outputs(input string pfx);
    logic e_oe;
    e_oe = (have_w && cyc > w_s && cyc <= w_s + w_l) ||
           (have_r && cyc > r_s && cyc <= r_s + T_RSTL);
    chk({pfx, "dq_oe"}, 32'(o_dq_oe), 32'(e_oe));
    chk({pfx, "busy"}, 32'(o_busy), 32'(in_write(cyc) || in_rst(cyc)));
    chk({pfx, "slot_done"}, 32'(o_slot_done), 32'(have_w && cyc == w_s + T_SLOT));
    chk({pfx, "frame_done"}, 32'(o_frame_done), 32'(fd_due == cyc));
    chk({pfx, "overrun"}, 32'(o_overrun), 32'(ov_m));
    chk({pfx, "presence"}, 32'(o_presence), 32'(pres_m));
    chk({pfx, "presence_valid"}, 32'(o_presence_valid),
        32'(have_r && cyc == r_s + T_RSTL + T_RSTH));
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic do_cycle(input logic b, input logic st, input logic dn, input logic rq);
    bit iw, ir, idl, start_r;
    i_bit = b; i_bit_strobe = st; i_done = dn; i_bus_reset_req = rq;
    i_dq = !(cyc >= pull_lo && cyc <= pull_hi);
    dq_hist[cyc & 65535] = i_dq;
    @(negedge clk);
    check_outputs("");
    if (o_slot_done === 1'b1) sd_cnt++;
    if (o_frame_done === 1'b1) fd_cnt++;
    if (!reset) begin
      iw = in_write(cyc); ir = in_rst(cyc); idl = !iw && !ir; start_r = 0;
      if (st && !idl) ov_m = 1'b1;
      if (iw && rq) pend = 1;
      if (dn) begin
        if (iw) done_pend = 1;
        else fd_due = cyc + 1;
      end
      if (iw && cyc == w_s + T_SLOT) begin
        if (done_pend) fd_due = cyc + 1;
        done_pend = 0;
        if (pend) start_r = 1;
        pend = 0;
      end
      if (idl && rq) start_r = 1;
      else if (idl && st) begin
        have_w = 1; w_s = cyc; w_l = b ? T_LOW1 : T_LOW0;
      end
      if (ir && cyc == r_s + T_RSTL + T_PDWAIT)
        pres_m = ~dq_hist[(cyc - 2) & 65535];
      if (start_r) begin
        have_r = 1; r_s = cyc; ov_m = 1'b0; pres_m = 1'b0;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [7:0] pat;
  int gap;

  initial begin
    reset = 1'b1;
    i_bit = 0; i_bit_strobe = 0; i_done = 0; i_bus_reset_req = 0; i_dq = 1;
    model_clear();
    @(posedge clk); #1;
    cyc = 0;
    idle(2);
    reset = 1'b0;

    // Single write-1 slot at cycle 10.
    while (cyc < 10) idle(1);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(75);

    // 0xA5 pattern, LSB first, 71-cycle bit period, i_done during last slot.
    pat = 8'hA5;
    sd_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      do_cycle(pat[i % 8], 1'b1, 1'b0, 1'b0);
      if (i == 63) begin
        idle(20);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        idle(55);
      end else begin
        idle(70);
      end
    end
    chk("pattern_slot_done_count", sd_cnt, 64);
    chk("pattern_frame_done_count", fd_cnt, 1);

    // Reset with presence pulse, then without.
    pull_lo = cyc + 500; pull_hi = cyc + 620;
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(965);
    chk("presence_after_pull", 32'(o_presence), 1);
    pull_lo = -1; pull_hi = -1;
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(965);
    chk("presence_no_pull", 32'(o_presence), 0);

    // Overrun 30 cycles into a write-0 slot, cleared by a later reset request.
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(29);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(45);
    chk("overrun_set", 32'(o_overrun), 1);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(965);

    // Reset request mid-slot, then simultaneous strobe and reset request.
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    idle(19);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1015);
    do_cycle(1'b1, 1'b1, 1'b0, 1'b1);
    idle(965);

    // Asynchronous reset while pulling low for a bus reset.
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idle(100);
    #2 reset = 1'b1;
    #1;
    model_clear();
    check_outputs("areset_");
    @(posedge clk); #1;
    cyc++;
    idle(2);
    reset = 1'b0;
    idle(3);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(75);

    // Randomized slots, frame ends and occasional reset requests.
    for (int it = 0; it < 30; it++) begin
      do_cycle(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 3) == 0), 1'b0);
      gap = $urandom_range(30, 90);
      for (int g = 0; g < gap; g++)
        do_cycle(1'b0, 1'b0, 1'($urandom_range(0, 40) == 0),
                 1'(g == 10 && $urandom_range(0, 7) == 0));
    end
    idle(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
